// File: rtl/systolic_array_ws.sv
// systolic_array_ws: weight-stationary systolic matrix unit.
//   A ROWS x COLS grid of signed MACs. Weights are loaded one row per beat
//   and then stay in place. Each accepted activation vector produces
//   o[c] = sum_r a[r]*W[r][c]. Activations move right through the grid and
//   partial sums move down it. Inputs are skewed per row and outputs are
//   deskewed per column, so each result vector leaves the array aligned,
//   ROWS+COLS advance-cycles after it was accepted.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start, num_vec        job start (sampled only in IDLE) and vector count
//   w_valid/w_ready/w_data weight rows (row 0 first); slice c = W[r][c]
//   a_valid/a_ready/a_data activation vectors; slice r = a[r]
//   o_valid/o_ready/o_data result vectors; slice c = o[c]
//   busy, done            busy outside IDLE; done pulses once per finished job

// One MAC cell. It holds its weight and adds its product to the partial sum
// coming from above.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] act_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_out
);
  logic signed [DATA_W-1:0]   w_q;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = $signed(act_in) * w_q;
  assign prod_ext = ACC_W'(prod);  // sign-extending cast

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q      <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w_q <= $signed(w_in);
      if (en)     psum_out <= psum_in + prod_ext;  // wraps modulo 2^ACC_W
    end
  end
endmodule

module systolic_array_ws #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [COLS*DATA_W-1:0] w_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DATA_W-1:0] a_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [COLS*ACC_W-1:0]  o_data,
  output logic                   busy,
  output logic                   done
);
  localparam int STAGES = ROWS + COLS;
  localparam int WCW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] nv, acnt, ocnt;
  logic [WCW-1:0]   wcnt;

  logic stall, adv, w_fire, a_fire, o_fire;

  logic [ROWS-1:0][DATA_W-1:0]           row_in;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] pe_act;
  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  psum;
  logic [COLS-1:0][ACC_W-1:0]            tail;
  logic [STAGES:1]                       vld_pipe;

  // The whole datapath advances in lockstep. It freezes only while a result
  // is waiting on the consumer.
  assign stall   = o_valid & ~o_ready;
  assign adv     = ~stall;
  assign w_fire  = w_valid & w_ready;
  assign a_ready = (state == S_COMPUTE) & ~stall & (acnt < nv);
  assign a_fire  = a_valid & a_ready;
  assign o_fire  = o_valid & o_ready;
  assign o_valid = vld_pipe[STAGES];

  // Control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      nv      <= '0;
      wcnt    <= '0;
      acnt    <= '0;
      ocnt    <= '0;
      w_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          if (num_vec != '0) begin
            nv      <= num_vec;
            wcnt    <= '0;
            w_ready <= 1'b1;
            busy    <= 1'b1;
            state   <= S_LOAD_W;
          end else begin
            done <= 1'b1;  // an empty job completes at once
          end
        end
        S_LOAD_W: if (w_fire) begin
          if (wcnt == WCW'(ROWS - 1)) begin
            w_ready <= 1'b0;
            acnt    <= '0;
            ocnt    <= '0;
            state   <= S_COMPUTE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (a_fire) begin
            acnt <= acnt + 1'b1;
            if (acnt == nv - 1'b1) state <= S_DRAIN;
          end
          if (o_fire) ocnt <= ocnt + 1'b1;
        end
        S_DRAIN: if (o_fire) begin
          ocnt <= ocnt + 1'b1;
          if (ocnt == nv - 1'b1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid tag: one bit per advance-cycle of latency. Bubbles travel as zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vld_pipe <= '0;
    else if (adv)  vld_pipe <= {vld_pipe[STAGES-1:1], a_fire};
  end

  // o_data changes only when a tagged vector arrives, so bubbles leave it as is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      o_data <= '0;
    else if (adv && vld_pipe[STAGES-1]) o_data <= tail;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int L = r + COLS - 1;

    assign row_in[r] = a_fire ? a_data[r*DATA_W +: DATA_W] : '0;

    // A single shift chain per row does two jobs. Tap r+c gives the
    // activation for PE(r,c), which is the row skew (r) plus the rightward
    // hop (c).
    if (L > 0) begin : g_chain
      logic [L:1][DATA_W-1:0] q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else if (adv) begin
          q[1] <= row_in[r];
          for (int k = 2; k <= L; k++) q[k] <= q[k-1];
        end
      end
      for (genvar c = 0; c < COLS; c++) begin : g_tap
        if (r + c == 0) begin : g_direct
          assign pe_act[r][c] = row_in[r];
        end else begin : g_reg
          assign pe_act[r][c] = q[r+c];
        end
      end
    end else begin : g_nochain
      assign pe_act[r][0] = row_in[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [ACC_W-1:0] psum_up;
      if (r == 0) begin : g_top
        assign psum_up = '0;
      end else begin : g_mid
        assign psum_up = psum[r-1][c];
      end

      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (adv),
        .w_load   (w_fire && (wcnt == WCW'(r))),
        .w_in     (w_data[c*DATA_W +: DATA_W]),
        .act_in   (pe_act[r][c]),
        .psum_in  (psum_up),
        .psum_out (psum[r][c])
      );
    end
  end

  // Column c finishes c cycles after column 0. Delaying it by COLS-1-c more
  // cycles brings all columns back into line.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_none
      assign tail[c] = psum[ROWS-1][c];
    end else begin : g_chain
      logic [D-1:0][ACC_W-1:0] dq;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dq <= '0;
        else if (adv) begin
          dq[0] <= psum[ROWS-1][c];
          for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
        end
      end
      assign tail[c] = dq[D-1];
    end
  end
endmodule

// File: tb/tb_systolic_array_ws.sv
module tb_systolic_array_ws;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // 4x4, ACC_W=32
  logic         start_a, w_valid_a, w_ready_a, a_valid_a, a_ready_a;
  logic         o_valid_a, o_ready_a, busy_a, done_a;
  logic [15:0]  nv_a;
  logic [31:0]  w_data_a, a_data_a;
  logic [127:0] o_data_a;
  // 2x3, ACC_W=20
  logic         start_b, w_valid_b, w_ready_b, a_valid_b, a_ready_b;
  logic         o_valid_b, o_ready_b, busy_b, done_b;
  logic [15:0]  nv_b;
  logic [23:0]  w_data_b;
  logic [15:0]  a_data_b;
  logic [59:0]  o_data_b;

  systolic_array_ws u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .num_vec(nv_a),
    .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
    .a_valid(a_valid_a), .a_ready(a_ready_a), .a_data(a_data_a),
    .o_valid(o_valid_a), .o_ready(o_ready_a), .o_data(o_data_a),
    .busy(busy_a), .done(done_a));

  systolic_array_ws #(.ROWS(2), .COLS(3), .ACC_W(20)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .num_vec(nv_b),
    .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
    .a_valid(a_valid_b), .a_ready(a_ready_b), .a_data(a_data_b),
    .o_valid(o_valid_b), .o_ready(o_ready_b), .o_data(o_data_b),
    .busy(busy_b), .done(done_b));

  int tests = 0, fails = 0;
  int wmat[4][4];
  int avec[32][4];
  logic [127:0] res_data[32];
  int res_cyc[32], app_cyc[32], acc_cyc[32];
  int n_res, n_acc, done_cyc, done_cnt, busy_at_done, stall_viol, w_ready_seen, busy_seen;

  function automatic logic [31:0] exp_a(int v, int c);
    int s = 0;
    for (int r = 0; r < 4; r++) s += avec[v][r] * wmat[r][c];
    return 32'(s);
  endfunction

  // Runs one job on the 4x4 array and records the handshake timing and the
  // results. With abort_at >= 0, reset is asserted once that many vectors
  // have been accepted.
  task automatic run_a(input int n, input int ready_rand, input int gap, input int abort_at);
    int cyc = 0, wi = 0, seen = 0, wx, ax;
    logic prev_stall = 1'b0;
    logic [127:0] prev_d = '0;
    n_res = 0; n_acc = 0; done_cyc = -1; done_cnt = 0; busy_at_done = -1;
    stall_viol = 0; w_ready_seen = 0; busy_seen = 0;
    @(negedge clk); start_a = 1'b1; nv_a = 16'(n);
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk); cyc++; start_a = 1'b0;
      if (prev_stall && (o_data_a !== prev_d || o_valid_a !== 1'b1)) stall_viol++;
      if (done_a) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = int'(busy_a); end
      end
      if (w_ready_a) w_ready_seen = 1;
      if (busy_a) busy_seen = 1;
      if (o_valid_a && !seen && n_res < 32) begin app_cyc[n_res] = cyc; seen = 1; end
      if (done_cyc > 0 && cyc >= done_cyc + 2) break;
      if (abort_at >= 0 && n_acc == abort_at) begin reset_n = 1'b0; #1; return; end
      wx = (wi < 4) ? wi : 0;
      ax = (n_acc < n && n_acc < 32) ? n_acc : 0;
      w_valid_a = (wi < 4);
      a_valid_a = (n_acc < n) && (gap == 0 || cyc % 2 == 0);
      for (int c = 0; c < 4; c++) w_data_a[c*8 +: 8] = 8'(wmat[wx][c]);
      for (int r = 0; r < 4; r++) a_data_a[r*8 +: 8] = 8'(avec[ax][r]);
      o_ready_a = ready_rand ? 1'($urandom % 2) : 1'b1;
      #1;
      if (w_valid_a && w_ready_a) wi++;
      if (a_valid_a && a_ready_a) begin acc_cyc[ax] = cyc; n_acc++; end
      if (o_valid_a && o_ready_a) begin
        if (n_res < 32) begin res_data[n_res] = o_data_a; res_cyc[n_res] = cyc; end
        n_res++; seen = 0;
      end
      prev_stall = o_valid_a && !o_ready_a;
      prev_d = o_data_a;
    end
    w_valid_a = 1'b0; a_valid_a = 1'b0; o_ready_a = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({o_valid_a, w_ready_a, a_ready_a, busy_a, done_a} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {o_valid_a, w_ready_a, a_ready_a, busy_a, done_a});
    end
    tests++;
    if (o_data_a !== '0 || o_data_b !== '0) begin
      fails++; $display("FAIL reset_odata: got %h/%h expected 0", o_data_a, o_data_b);
    end
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({o_valid_a, busy_a, o_valid_b, busy_b} !== 4'b0) begin
      fails++; $display("FAIL reset_release: got %b expected 0000", {o_valid_a, busy_a, o_valid_b, busy_b});
    end
  endtask

  task automatic test_zero_job();
    run_a(0, 0, 0, -1);
    tests++;
    if (done_cyc !== 1) begin fails++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    tests++;
    if (w_ready_seen !== 0) begin fails++; $display("FAIL zero_w_ready: got %0d expected 0", w_ready_seen); end
    tests++;
    if (busy_seen !== 0) begin fails++; $display("FAIL zero_busy: got %0d expected 0", busy_seen); end
  endtask

  task automatic test_identity();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = (r == c) ? 1 : 0;
    avec[0] = '{1, 2, 3, 4};
    run_a(1, 0, 0, -1);
    tests++;
    if (n_res !== 1) begin fails++; $display("FAIL ident_count: got %0d expected 1", n_res); end
    tests++;
    if (res_data[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      fails++; $display("FAIL ident_data: got %h expected 4,3,2,1", res_data[0]);
    end
    tests++;
    if (app_cyc[0] - acc_cyc[0] !== 8) begin
      fails++; $display("FAIL ident_latency: got %0d expected 8", app_cyc[0] - acc_cyc[0]);
    end
    tests++;
    if (done_cyc - res_cyc[0] !== 1) begin
      fails++; $display("FAIL ident_done_gap: got %0d expected 1", done_cyc - res_cyc[0]);
    end
    tests++;
    if (busy_at_done !== 0 || done_cnt !== 1) begin
      fails++; $display("FAIL ident_done_busy: got busy %0d pulses %0d expected 0 1", busy_at_done, done_cnt);
    end
  endtask

  task automatic test_extremes();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = -1;
    avec[0] = '{127, 127, 127, 127};
    run_a(1, 0, 0, -1);
    tests++;
    if (res_data[0] !== {4{32'hFFFFFE04}}) begin
      fails++; $display("FAIL ext_neg: got %h expected 4x fffffe04", res_data[0]);
    end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = -128;
    avec[0] = '{-128, -128, -128, -128};
    run_a(1, 0, 0, -1);
    tests++;
    if (res_data[0] !== {4{32'd65536}}) begin
      fails++; $display("FAIL ext_min: got %h expected 4x 00010000", res_data[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = (r == c) ? 1 : 0;
    for (int k = 0; k < 6; k++) avec[k] = '{k + 1, 2 * (k + 1), -(k + 1), 0};
    run_a(6, 0, 0, -1);
    tests++;
    if (acc_cyc[5] - acc_cyc[0] !== 5 || res_cyc[5] - res_cyc[0] !== 5) begin
      fails++; $display("FAIL b2b_rate: got acc %0d res %0d expected 5 5", acc_cyc[5] - acc_cyc[0], res_cyc[5] - res_cyc[0]);
    end
    for (int k = 0; k < 6; k++) begin
      logic [127:0] e;
      e = {32'd0, 32'(-(k + 1)), 32'(2 * (k + 1)), 32'(k + 1)};
      tests++;
      if (res_data[k] !== e) begin fails++; $display("FAIL b2b_data%0d: got %h expected %h", k, res_data[k], e); end
    end
  endtask

  task automatic test_random_backpressure();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = int'($urandom_range(0, 255)) - 128;
    for (int v = 0; v < 16; v++) for (int r = 0; r < 4; r++) avec[v][r] = int'($urandom_range(0, 255)) - 128;
    run_a(16, 1, 0, -1);
    tests++;
    if (n_res !== 16 || done_cnt !== 1) begin
      fails++; $display("FAIL rand_count: got %0d results %0d done expected 16 1", n_res, done_cnt);
    end
    tests++;
    if (stall_viol !== 0) begin fails++; $display("FAIL rand_stall_hold: got %0d changes expected 0", stall_viol); end
    for (int v = 0; v < 16; v++) begin
      logic [127:0] e;
      for (int c = 0; c < 4; c++) e[c*32 +: 32] = exp_a(v, c);
      tests++;
      if (res_data[v] !== e) begin fails++; $display("FAIL rand_vec%0d: got %h expected %h", v, res_data[v], e); end
    end
  endtask

  task automatic test_reset_mid_job();
    int stray = 0;
    run_a(8, 0, 1, 3);
    tests++;
    if ({o_valid_a, w_ready_a, a_ready_a, busy_a, done_a} !== 5'b0 || o_data_a !== '0) begin
      fails++; $display("FAIL midrst_outputs: got ctrl %b data %h expected all 0",
                        {o_valid_a, w_ready_a, a_ready_a, busy_a, done_a}, o_data_a);
    end
    w_valid_a = 1'b0; a_valid_a = 1'b0; o_ready_a = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    repeat (12) begin @(negedge clk); if (o_valid_a || busy_a) stray++; end
    tests++;
    if (stray !== 0) begin fails++; $display("FAIL midrst_stale: got %0d cycles expected 0", stray); end
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) wmat[r][c] = 1;
    avec[0] = '{1, 2, 3, 4};
    avec[1] = '{-1, -1, -1, -1};
    run_a(2, 0, 0, -1);
    tests++;
    if (n_res !== 2) begin fails++; $display("FAIL midrst_count: got %0d expected 2", n_res); end
    tests++;
    if (res_data[0] !== {4{32'd10}} || res_data[1] !== {4{32'hFFFFFFFC}}) begin
      fails++; $display("FAIL midrst_data: got %h %h expected 4x0a 4xfffffffc", res_data[0], res_data[1]);
    end
  endtask

  task automatic test_small_array();
    logic [23:0] wrow[2];
    logic [15:0] av[3];
    logic [59:0] exp_b[3], got_b[3];
    int cyc = 0, wi = 0, ai = 0, nr = 0, ovc = 0, dseen = -1, acc0 = -1, app0 = -1;
    wrow[0] = {8'd3, 8'd2, 8'd1};
    wrow[1] = {8'd6, 8'd5, 8'd4};
    av[0] = {8'd1, 8'd1};
    av[1] = {8'hFF, 8'd2};
    av[2] = {8'd3, 8'd0};
    exp_b[0] = {20'd9, 20'd7, 20'd5};
    exp_b[1] = {20'd0, 20'hFFFFF, 20'hFFFFE};
    exp_b[2] = {20'd18, 20'd15, 20'd12};
    got_b[0] = '0; got_b[1] = '0; got_b[2] = '0;
    @(negedge clk); start_b = 1'b1; nv_b = 16'd3; o_ready_b = 1'b1;
    for (int t = 0; t < 60 && dseen < 0; t++) begin
      @(negedge clk); cyc++; start_b = 1'b0;
      if (done_b) dseen = cyc;
      if (o_valid_b) begin
        ovc++;
        if (app0 < 0) app0 = cyc;
        if (nr < 3) got_b[nr] = o_data_b;
        nr++;
      end
      w_valid_b = (wi < 2);
      w_data_b  = wrow[(wi < 2) ? wi : 0];
      a_valid_b = (ai < 3) && (cyc % 3 == 0);
      a_data_b  = av[(ai < 3) ? ai : 0];
      #1;
      if (w_valid_b && w_ready_b) wi++;
      if (a_valid_b && a_ready_b) begin if (acc0 < 0) acc0 = cyc; ai++; end
    end
    w_valid_b = 1'b0; a_valid_b = 1'b0;
    tests++;
    if (dseen < 0) begin fails++; $display("FAIL small_done: got none expected a pulse"); end
    tests++;
    if (ovc !== 3) begin fails++; $display("FAIL small_valid_count: got %0d expected 3", ovc); end
    tests++;
    if (app0 - acc0 !== 5) begin fails++; $display("FAIL small_latency: got %0d expected 5", app0 - acc0); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (got_b[k] !== exp_b[k]) begin fails++; $display("FAIL small_vec%0d: got %h expected %h", k, got_b[k], exp_b[k]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; nv_a = '0; w_valid_a = 1'b0; w_data_a = '0; a_valid_a = 1'b0; a_data_a = '0; o_ready_a = 1'b1;
    start_b = 1'b0; nv_b = '0; w_valid_b = 1'b0; w_data_b = '0; a_valid_b = 1'b0; a_data_b = '0; o_ready_b = 1'b1;
    test_reset();
    test_zero_job();
    test_identity();
    test_extremes();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid_job();
    test_small_array();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
